// File: rtl/dot_accumulator_if.sv
// Bus between the multiplier stage, the dot-product accumulator and the
// downstream consumer: product input, sum output and the dav_/rfd handshake.
interface dot_accumulator_if #(
    parameter int W = 18
);
    logic [15:0]  m;     // product from the multiplier
    logic         ok;    // product-valid level
    logic [W-1:0] s;     // completed sum
    logic         dav_;  // data available, active low
    logic         rfd;   // ready for data from downstream
    logic         ovr;   // sticky product-dropped flag

    // Driver side: multiplier plus downstream stage
    modport master (
        output m, ok, rfd,
        input  s, dav_, ovr
    );

    // Accumulator side
    modport slave (
        input  m, ok, rfd,
        output s, dav_, ovr
    );
endinterface

// File: rtl/dot_accumulator.sv
// Dot-product accumulator: sums N consecutive products (one per rising edge
// of ok), presents each sum over a dav_/rfd handshake and buffers a single
// product that arrives while the handshake is still open.
module dot_accumulator #(
    parameter int N = 4,
    parameter int W = 18
) (
    input  logic                clock,
    input  logic                reset,
    dot_accumulator_if.slave    bus
);
    typedef enum logic [1:0] {
        ACC_S = 2'b00,
        OUT_S = 2'b01,
        HS_S  = 2'b10
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    state_t       state_q;
    logic [W-1:0] acc_q;
    logic [7:0]   cnt_q;
    logic         pendv_q;
    logic [15:0]  pend_q;
    logic         okr_q;
    logic [W-1:0] s_q;
    logic         dav_n_q;
    logic         ovr_q;

    logic         edge_s;
    logic [W-1:0] m_ext_s;
    logic [W-1:0] pend_ext_s;
    logic [W-1:0] acc_plus_m_s;
    logic [W-1:0] pend_plus_m_s;

    // A product is counted once per rising edge of ok, however long ok stays high
    assign edge_s        = bus.ok & ~okr_q;
    assign m_ext_s       = {{(W-16){1'b0}}, bus.m};
    assign pend_ext_s    = {{(W-16){1'b0}}, pend_q};
    assign acc_plus_m_s  = acc_q + m_ext_s;
    assign pend_plus_m_s = pend_ext_s + m_ext_s;

    assign bus.s    = s_q;
    assign bus.dav_ = dav_n_q;
    assign bus.ovr  = ovr_q;

    // Accumulate/output/handshake state machine with all outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ACC_S;
            acc_q   <= {W{1'b0}};
            cnt_q   <= 8'd0;
            pendv_q <= 1'b0;
            pend_q  <= 16'd0;
            okr_q   <= 1'b0;
            s_q     <= {W{1'b0}};
            dav_n_q <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            okr_q <= bus.ok;
            case (state_q)
                ACC_S: begin
                    if (edge_s) begin
                        if (cnt_q == LAST_CNT) begin
                            s_q     <= acc_plus_m_s;
                            dav_n_q <= 1'b0;
                            acc_q   <= {W{1'b0}};
                            cnt_q   <= 8'd0;
                            state_q <= OUT_S;
                        end else begin
                            acc_q <= acc_plus_m_s;
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                OUT_S: begin
                    // One product may be parked while the sum is on offer
                    if (edge_s) begin
                        if (!pendv_q) begin
                            pend_q  <= bus.m;
                            pendv_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                    if (!bus.rfd) begin
                        dav_n_q <= 1'b1;
                        state_q <= HS_S;
                    end
                end
                HS_S: begin
                    if (bus.rfd) begin
                        // Restart from the parked product plus any product on this clock
                        state_q <= ACC_S;
                        pendv_q <= 1'b0;
                        case ({pendv_q, edge_s})
                            2'b00: begin
                                acc_q <= {W{1'b0}};
                                cnt_q <= 8'd0;
                            end
                            2'b01: begin
                                acc_q <= m_ext_s;
                                cnt_q <= 8'd1;
                            end
                            2'b10: begin
                                acc_q <= pend_ext_s;
                                cnt_q <= 8'd1;
                            end
                            2'b11: begin
                                acc_q <= pend_plus_m_s;
                                cnt_q <= 8'd2;
                            end
                            default: begin
                                acc_q <= {W{1'b0}};
                                cnt_q <= 8'd0;
                            end
                        endcase
                    end else if (edge_s) begin
                        if (!pendv_q) begin
                            pend_q  <= bus.m;
                            pendv_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ACC_S;
                    dav_n_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator: a table of directed cycles,
// hand-written handshake/overrun/reset sequences and a randomized run,
// all also compared against a queue-based reference model.
module tb_dot_accumulator;
    localparam int N = 4;
    localparam int W = 18;

    logic clock = 1'b0;
    logic reset = 1'b1;

    dot_accumulator_if #(.W(W)) bus ();

    dot_accumulator #(.N(N), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int unsigned  q_prod[$];   // products of the sum being built
    int unsigned  q_pend[$];   // product parked during output
    bit           mdl_busy;    // a sum is out, handshake not finished
    bit           mdl_closing; // rfd=0 seen, waiting for rfd=1
    bit           mdl_okp;
    logic [W-1:0] mdl_s;
    bit           mdl_ovr;

    function automatic void model_reset();
        q_prod.delete();
        q_pend.delete();
        mdl_busy    = 1'b0;
        mdl_closing = 1'b0;
        mdl_okp     = 1'b0;
        mdl_s       = '0;
        mdl_ovr     = 1'b0;
    endfunction

    function automatic void model_park(int unsigned v);
        if (q_pend.size() == 0) q_pend.push_back(v);
        else mdl_ovr = 1'b1;
    endfunction

    function automatic void model_clock(bit ok, int unsigned mv, bit rfd);
        bit e;
        int unsigned tot;
        e = ok && !mdl_okp;
        mdl_okp = ok;
        if (!mdl_busy) begin
            if (e) q_prod.push_back(mv);
            if (q_prod.size() == N) begin
                tot = 0;
                foreach (q_prod[i]) tot += q_prod[i];
                mdl_s = tot[W-1:0];
                q_prod.delete();
                mdl_busy = 1'b1;
                mdl_closing = 1'b0;
            end
        end else if (!mdl_closing) begin
            if (e) model_park(mv);
            if (!rfd) mdl_closing = 1'b1;
        end else if (rfd) begin
            mdl_busy = 1'b0;
            q_prod = q_pend;
            q_pend.delete();
            if (e) q_prod.push_back(mv);
        end else if (e) begin
            model_park(mv);
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic dav, input logic [W-1:0] s, input logic ovr);
        chk({name, ".dav_"}, {31'd0, bus.dav_}, {31'd0, dav});
        chk({name, ".s"}, {{(32-W){1'b0}}, bus.s}, {{(32-W){1'b0}}, s});
        chk({name, ".ovr"}, {31'd0, bus.ovr}, {31'd0, ovr});
    endtask

    // One clock: model sees the same inputs as the DUT, compare at negedge
    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_clock(bus.ok, 32'(bus.m), bus.rfd);
        @(negedge clock);
        chk("model.dav_", {31'd0, bus.dav_}, {31'd0, !(mdl_busy && !mdl_closing)});
        chk("model.s", {{(32-W){1'b0}}, bus.s}, {{(32-W){1'b0}}, mdl_s});
        chk("model.ovr", {31'd0, bus.ovr}, {31'd0, mdl_ovr});
    endtask

    task automatic pulse(input logic [15:0] v);
        bus.m  = v;
        bus.ok = 1'b1;
        step();
        bus.ok = 1'b0;
        step();
    endtask

    task automatic close_hs();
        bus.rfd = 1'b0;
        step();
        bus.rfd = 1'b1;
        step();
    endtask

    typedef struct {
        logic         ok;
        logic [15:0]  m;
        logic         rfd;
        logic         exp_dav;
        logic [W-1:0] exp_s;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // products 3,5,7,11 -> 26; handshake; then 1,2,3,4 -> 10 proves ACC restarted at 0
        tbl[0]  = '{1'b1, 16'd3,  1'b1, 1'b1, 18'd0,  1'b0};
        tbl[1]  = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd0,  1'b0};
        tbl[2]  = '{1'b1, 16'd5,  1'b1, 1'b1, 18'd0,  1'b0};
        tbl[3]  = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd0,  1'b0};
        tbl[4]  = '{1'b1, 16'd7,  1'b1, 1'b1, 18'd0,  1'b0};
        tbl[5]  = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd0,  1'b0};
        tbl[6]  = '{1'b1, 16'd11, 1'b1, 1'b0, 18'd26, 1'b0};
        tbl[7]  = '{1'b0, 16'd0,  1'b1, 1'b0, 18'd26, 1'b0};
        tbl[8]  = '{1'b0, 16'd0,  1'b0, 1'b1, 18'd26, 1'b0};
        tbl[9]  = '{1'b0, 16'd0,  1'b0, 1'b1, 18'd26, 1'b0};
        tbl[10] = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[11] = '{1'b1, 16'd1,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[12] = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[13] = '{1'b1, 16'd2,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[14] = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[15] = '{1'b1, 16'd3,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[16] = '{1'b0, 16'd0,  1'b1, 1'b1, 18'd26, 1'b0};
        tbl[17] = '{1'b1, 16'd4,  1'b1, 1'b0, 18'd10, 1'b0};
        tbl[18] = '{1'b0, 16'd0,  1'b1, 1'b0, 18'd10, 1'b0};

        model_reset();
        bus.m   = 16'd0;
        bus.ok  = 1'b0;
        bus.rfd = 1'b1;
        repeat (3) @(negedge clock);
        chk_out("reset", 1'b1, 18'd0, 1'b0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 19; i++) begin
            bus.ok  = tbl[i].ok;
            bus.m   = tbl[i].m;
            bus.rfd = tbl[i].rfd;
            step();
            chk_out($sformatf("tbl%0d", i), tbl[i].exp_dav, tbl[i].exp_s, tbl[i].exp_ovr);
        end

        // T4: product during OUT_S with rfd held high is parked, then seeds next sum
        pulse(16'd65535);
        chk_out("t4_parked", 1'b0, 18'd10, 1'b0);
        close_hs();
        chk_out("t4_closed", 1'b1, 18'd10, 1'b0);
        for (int k = 0; k < 3; k++) pulse(16'd65535);
        chk_out("t4_sum", 1'b0, 18'd262140, 1'b0);
        close_hs();

        // T2: ok held high for 10 clocks counts once
        bus.m  = 16'd100;
        bus.ok = 1'b1;
        repeat (10) step();
        chk_out("t2_hold", 1'b1, 18'd262140, 1'b0);
        bus.ok = 1'b0;
        step();
        for (int k = 0; k < 3; k++) pulse(16'd1);
        chk_out("t2_sum", 1'b0, 18'd103, 1'b0);

        // T5: two products while output pending -> second dropped, ovr sticky
        pulse(16'd7);
        pulse(16'd9);
        chk_out("t5_ovr", 1'b0, 18'd103, 1'b1);
        close_hs();
        for (int k = 0; k < 3; k++) pulse(16'd1);
        chk_out("t5_sum", 1'b0, 18'd10, 1'b1);

        // T6: asynchronous reset in the middle of a handshake with a parked product
        pulse(16'd5);
        #2;
        reset = 1'b1;
        #1;
        chk_out("t6_async", 1'b1, 18'd0, 1'b0);
        step();
        reset = 1'b0;
        pulse(16'd2);
        pulse(16'd3);
        pulse(16'd4);
        chk_out("t6_partial", 1'b1, 18'd0, 1'b0);
        pulse(16'd5);
        chk_out("t6_sum", 1'b0, 18'd14, 1'b0);
        close_hs();

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            if (bus.ok) begin
                bus.ok = ($urandom_range(0, 2) == 0);
            end else begin
                bus.ok = ($urandom_range(0, 2) == 0);
                if (bus.ok) bus.m = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            end
            bus.rfd = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
